// File: rtl/instr_encoder.sv
// Symbolic instruction request to MIPS machine-word assembler.
// Writes encoded words sequentially into instruction memory over a backpressured port.
module instr_encoder #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_shamt,
    input  logic [31:0]       req_imm,
    input  logic              restart,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ready,
    output logic [ADDR_W:0]   word_count,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CNT_MAX = {(ADDR_W+1){1'b1}};
    localparam logic [4:0]        OP_LI   = 5'd23;

    typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, EMIT_HI = 2'd2} state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [31:0]       data_r, data_s;
    logic [31:0]       lo_r, lo_s;
    logic [ADDR_W:0]   count_r, count_s;
    logic              err_r, err_s;
    logic              acc_s, load_s, written_s;

    // First (or only) machine word of a request; LI yields its LUI half here.
    function automatic logic [31:0] enc_word(input logic [4:0] op, rd, rs, rt, shamt,
                                             input logic [31:0] imm);
        logic [31:0] w;
        w = 32'h0000_0000;
        case (op)
            5'd1:    w = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            5'd2:    w = {6'h00, rs, rt, rd, 5'd0, 6'h22};
            5'd3:    w = {6'h00, rs, rt, rd, 5'd0, 6'h24};
            5'd4:    w = {6'h00, rs, rt, rd, 5'd0, 6'h25};
            5'd5:    w = {6'h00, rs, rt, rd, 5'd0, 6'h26};
            5'd6:    w = {6'h00, 5'd0, rt, rd, shamt, 6'h00};
            5'd7:    w = {6'h00, 5'd0, rt, rd, shamt, 6'h02};
            5'd8:    w = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            5'd9:    w = {6'h00, rs, 15'd0, 6'h08};
            5'd10:   w = {6'h00, rs, 5'd0, rd, 5'd0, 6'h09};
            5'd11:   w = {6'h08, rs, rt, imm[15:0]};
            5'd12:   w = {6'h0C, rs, rt, imm[15:0]};
            5'd13:   w = {6'h0D, rs, rt, imm[15:0]};
            5'd14:   w = {6'h0E, rs, rt, imm[15:0]};
            5'd15:   w = {6'h23, rs, rt, imm[15:0]};
            5'd16:   w = {6'h2B, rs, rt, imm[15:0]};
            5'd17:   w = {6'h0F, 5'd0, rt, imm[15:0]};
            5'd18:   w = {6'h0A, rs, rt, imm[15:0]};
            5'd19:   w = {6'h04, rs, rt, imm[15:0]};
            5'd20:   w = {6'h05, rs, rt, imm[15:0]};
            5'd21:   w = {6'h02, imm[25:0]};
            5'd22:   w = {6'h03, imm[25:0]};
            5'd23:   w = {6'h0F, 5'd0, rt, imm[31:16]};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    assign req_ready  = ~restart & ((state_r == IDLE) | ((state_r == EMIT) & wr_ready));
    assign acc_s      = req_valid & req_ready;
    assign wr_en      = (state_r != IDLE);
    assign wr_addr    = addr_r;
    assign wr_data    = data_r;
    assign word_count = count_r;
    assign err        = err_r;

    // Next-state, address/count advance and request loading.
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        data_s    = data_r;
        lo_s      = lo_r;
        count_s   = count_r;
        err_s     = err_r;
        load_s    = 1'b0;
        written_s = 1'b0;
        if (restart) begin
            state_s = IDLE;
            addr_s  = BASE;
            count_s = {(ADDR_W+1){1'b0}};
            err_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    load_s = acc_s;
                end
                EMIT: begin
                    if (wr_ready) begin
                        written_s = 1'b1;
                        state_s   = IDLE;
                        load_s    = acc_s;
                    end else begin
                        state_s = EMIT;
                    end
                end
                EMIT_HI: begin
                    if (wr_ready) begin
                        written_s = 1'b1;
                        data_s    = lo_r;
                        state_s   = EMIT;
                    end else begin
                        state_s = EMIT_HI;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
            if (written_s) begin
                addr_s  = addr_r + ADDR_W'(1);
                count_s = (count_r == CNT_MAX) ? count_r : count_r + (ADDR_W+1)'(1);
            end else begin
                addr_s = addr_r;
            end
            // Illegal opcodes raise the sticky flag and produce no word.
            if (load_s) begin
                if (req_op <= OP_LI) begin
                    data_s  = enc_word(req_op, req_rd, req_rs, req_rt, req_shamt, req_imm);
                    lo_s    = {6'h0D, req_rt, req_rt, req_imm[15:0]};
                    state_s = (req_op == OP_LI) ? EMIT_HI : EMIT;
                end else begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end
            end else begin
                lo_s = lo_r;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            addr_r  <= BASE;
            data_r  <= 32'h0000_0000;
            lo_r    <= 32'h0000_0000;
            count_r <= {(ADDR_W+1){1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            data_r  <= data_s;
            lo_r    <= lo_s;
            count_r <= count_s;
            err_r   <= err_s;
        end
    end

endmodule
